// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul PE-array sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package matmul_pkg;

    localparam int MAX_DIM     = 4;
    localparam int SP_NTARGETS = 4;
    localparam int DIM_W       = $clog2(MAX_DIM) + 1;
    localparam int TGT_W       = $clog2(SP_NTARGETS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FETCH = 3'd2,
        FEED  = 3'd3,
        WB    = 3'd4,
        DONE  = 3'd5
    } sched_state_e;

    typedef struct packed {
        logic [DIM_W-1:0] n;
        logic [DIM_W-1:0] k;
        logic [DIM_W-1:0] m;
        logic             mode;
        logic [TGT_W-1:0] target;
    } sched_cfg_t;

    // A dimension is usable when it is non-zero and fits the PE array.
    function automatic logic dim_ok(input logic [DIM_W-1:0] d);
        return (d != '0) && (d <= DIM_W'(MAX_DIM));
    endfunction

endpackage

// File: rtl/matmul_sched_cnt.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
// Latency: load/decrement visible the cycle after the request.
// Backpressure: none; load has priority over decrement.
module matmul_sched_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise step down but never below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/matmul_sched.sv
// Sequencer for the matmul PE array: clear, operand fetch, skewed feed, scratchpad writeback.
// Latency: done 3+F+N cycles after start (4+F+N in accumulate mode), F = K+N+M-2.
// Backpressure: none; start is only accepted in IDLE, otherwise ignored.
module matmul_sched #(
    parameter int MAX_DIM     = matmul_pkg::MAX_DIM,
    parameter int SP_NTARGETS = matmul_pkg::SP_NTARGETS,
    parameter int DIM_W       = $clog2(MAX_DIM) + 1,
    parameter int TGT_W       = $clog2(SP_NTARGETS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [DIM_W-1:0] n_dim_i,
    input  logic [DIM_W-1:0] k_dim_i,
    input  logic [DIM_W-1:0] m_dim_i,
    input  logic             mode_i,
    input  logic [TGT_W-1:0] wr_target_i,
    output logic             opmem_rd_en_o,
    output logic [DIM_W-1:0] opmem_rd_addr_o,
    output logic             pe_clear_o,
    output logic             pe_shift_o,
    output logic             operand_valid_o,
    output logic             sp_rd_en_o,
    output logic             sp_wr_en_o,
    output logic [TGT_W-1:0] sp_target_o,
    output logic [DIM_W-1:0] sp_row_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    import matmul_pkg::*;

    // Feed counter holds up to K+N+M-3, which needs more bits than a dimension.
    localparam int FEED_W = $clog2(3 * MAX_DIM);

    sched_state_e     state_q, state_d;
    sched_cfg_t       cfg_q, cfg_d;
    logic             err_q, err_d;
    logic [DIM_W-1:0] row_dly_q, row_dly_d;

    logic              accept;
    logic              dims_ok;
    logic              feed_load, feed_dec, feed_zero;
    logic [FEED_W-1:0] feed_last, feed_cnt, feed_f;
    logic              wb_load, wb_dec, wb_zero;
    logic [DIM_W-1:0]  wb_last, wb_cnt, wb_j;

    assign accept  = (state_q == IDLE) && start_i;
    assign dims_ok = dim_ok(n_dim_i) && dim_ok(k_dim_i) && dim_ok(m_dim_i);

    // Feed phase: load F-1 during FETCH, count down once per FEED cycle.
    assign feed_last = FEED_W'(cfg_q.k) + FEED_W'(cfg_q.n) + FEED_W'(cfg_q.m) - FEED_W'(3);
    assign feed_load = (state_q == FETCH);
    assign feed_dec  = (state_q == FEED);
    assign feed_f    = feed_last - feed_cnt;

    matmul_sched_cnt #(.W(FEED_W)) u_feed_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (feed_load),
        .load_val_i (feed_last),
        .dec_i      (feed_dec),
        .cnt_o      (feed_cnt),
        .zero_o     (feed_zero)
    );

    // Writeback phase: N cycles, or N+1 when the read/write pipeline is in use.
    assign wb_last = cfg_q.mode ? cfg_q.n : (cfg_q.n - DIM_W'(1));
    assign wb_load = (state_q == FEED) && feed_zero;
    assign wb_dec  = (state_q == WB);
    assign wb_j    = wb_last - wb_cnt;

    matmul_sched_cnt #(.W(DIM_W)) u_wb_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (wb_load),
        .load_val_i (wb_last),
        .dec_i      (wb_dec),
        .cnt_o      (wb_cnt),
        .zero_o     (wb_zero)
    );

    // Latch the job on an accepted start; the error flag is rebuilt from the new dims.
    always_comb begin
        cfg_d     = cfg_q;
        err_d     = err_q;
        row_dly_d = (state_q == WB) ? wb_j : '0;
        if (accept) begin
            cfg_d.n      = n_dim_i;
            cfg_d.k      = k_dim_i;
            cfg_d.m      = m_dim_i;
            cfg_d.mode   = mode_i;
            cfg_d.target = wr_target_i;
            err_d        = !dims_ok;
        end
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cfg_q     <= '0;
            err_q     <= 1'b0;
            row_dly_q <= '0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            err_q     <= err_d;
            row_dly_q <= row_dly_d;
        end
    end

    // Phase sequencing; illegal dims skip straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = dims_ok ? CLEAR : DONE;
            CLEAR:   state_d = FETCH;
            FETCH:   state_d = FEED;
            FEED:    if (feed_zero) state_d = WB;
            WB:      if (wb_zero) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes decoded from the current phase and its counter position.
    always_comb begin
        opmem_rd_en_o   = 1'b0;
        opmem_rd_addr_o = '0;
        pe_clear_o      = 1'b0;
        pe_shift_o      = 1'b0;
        operand_valid_o = 1'b0;
        sp_rd_en_o      = 1'b0;
        sp_wr_en_o      = 1'b0;
        sp_target_o     = '0;
        sp_row_o        = '0;
        busy_o          = 1'b0;
        done_o          = 1'b0;
        case (state_q)
            CLEAR: begin
                busy_o     = 1'b1;
                pe_clear_o = 1'b1;
            end
            FETCH: begin
                busy_o        = 1'b1;
                opmem_rd_en_o = 1'b1;
            end
            FEED: begin
                busy_o          = 1'b1;
                pe_shift_o      = 1'b1;
                operand_valid_o = (feed_f < FEED_W'(cfg_q.k));
                // Prefetch the next k index one cycle ahead of injection.
                if (feed_f < (FEED_W'(cfg_q.k) - FEED_W'(1))) begin
                    opmem_rd_en_o   = 1'b1;
                    opmem_rd_addr_o = DIM_W'(feed_f + FEED_W'(1));
                end
            end
            WB: begin
                busy_o      = 1'b1;
                sp_target_o = cfg_q.target;
                if (cfg_q.mode) begin
                    // Read row j while writing row j-1 (scratchpad read latency 1).
                    sp_rd_en_o = !wb_zero;
                    sp_wr_en_o = (wb_j != '0);
                    sp_row_o   = (wb_j != '0) ? row_dly_q : wb_j;
                end else begin
                    sp_wr_en_o = 1'b1;
                    sp_row_o   = wb_j;
                end
            end
            DONE: begin
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign err_o = err_q;

endmodule
